accumulator_unit: RTL and testbench
===================================

Name: accumulator_unit

Overview:
- Datapath stage directly downstream of control_block in the 8-bit CPU.
- Holds the double-length accumulator: AH (high byte) and AL (low byte).
- Executes control_block's one-hot ALU strobes (adds/subs/ands/muls/divs) against the B-register operand.
- Applies hs/ls shift/load modes, drives AL onto the W bus under acc_oen, and returns z_f/s_f to control_block.
- Multiply and divide run iteratively, one bit per clock, sequenced by an internal step counter.

Parameters:
- WIDTH, 8, byte width of AH, AL, bus and operand.
- STEPS, 8, mul/div iterations; must equal WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  synchronous, active-low reset.
- bus_in  input  8  W-bus data used for parallel loads.
- breg_in  input  8  B-register operand.
- ah_inen  input  1  write ALU result to AH; with no op strobe, load bus_in into AH.
- ah_reset  input  1  clear AH.
- adds, subs, ands, muls, divs  input  1 each  one-hot operation strobes.
- hs  input  2  AH mode: 00 hold, 01 shift right (0 in), 10 shift left (0 in), 11 load bus_in.
- ls  input  2  AL mode, same encoding as hs.
- acc_oen  input  1  drive AL onto acc_out.
- acc_out  output  8  AL when acc_oen=1, else 8'h00.
- ah_out  output  8  AH contents, always visible.
- z_f  output  1  registered zero flag.
- s_f  output  1  registered sign flag.
- md_done  output  1  one-cycle pulse on the final mul/div step.

Behaviour:
- Reset: clr=0 at a rising edge clears AH, AL, the 4-bit step counter, z_f, s_f and md_done. acc_out=0. Reset overrides every other input, including mid mul/div.
- Strobe priority if more than one is asserted: muls > divs > subs > adds > ands.
- AH write priority: ah_reset > mul/div step > ah_inen > hs mode.
- AL write priority: mul/div step > ls mode.
- ALU ops are single-cycle and take effect only when ah_inen=1:
  - adds: AH <= AH + breg_in (mod 256).
  - subs: AH <= AH - breg_in (mod 256).
  - ands: AH <= AH & breg_in.
  - On the same edge: z_f <= (result==0), s_f <= result[7].
- Multiply (unsigned shift-add). Precondition: AH=0, AL=multiplier, breg_in=multiplicand. Each cycle with muls=1:
  - sum[8:0] = AL[0] ? AH + breg_in : {0,AH}.
  - AH <= sum[8:1]; AL <= {sum[0], AL[7:1]}; counter increments.
- Divide (unsigned restoring). Precondition: AH=0, AL=dividend, breg_in=divisor. Each cycle with divs=1:
  - t[8:0] = {AH, AL[7]}; d = t - breg_in.
  - If t >= breg_in: AH <= d[7:0], AL <= {AL[6:0], 1}.
  - Else: AH <= t[7:0], AL <= {AL[6:0], 0}.
  - Counter increments.
- Completion (step 8 edge):
  - md_done=1 for exactly that cycle; counter returns to 0.
  - z_f <= ({AH,AL}_new == 0); s_f <= AH_new[7].
  - Multiply result: {AH,AL} = 16-bit product.
  - Divide result: AL = quotient, AH = remainder.
- Divide by zero needs no special case: the algorithm yields AL=8'hFF, AH=dividend.
- Abort: if muls/divs deasserts before step 8, counter clears on the next edge and registers keep their partial values. No md_done, flags unchanged.
- Switching muls to divs mid-sequence counts as abort and restart; counter restarts at 0.
- Flags change only on ALU writes and md_done. hs/ls loads and shifts leave flags unchanged.
- Latency:
  - ALU op: result and flags visible 1 cycle after the strobe edge.
  - mul/div: result visible after 8 consecutive strobe cycles.
  - acc_out: combinational from AL and acc_oen.

Test Plan:
- Reset: load AH=5A, AL=C3, then clr=0 for one edge -> AH, AL, z_f, s_f, md_done all 0; acc_out=00 with acc_oen=1.
- ALU: hs=11, bus_in=7F; then breg=01, adds+ah_inen -> AH=80, s_f=1, z_f=0. Then breg=80, subs+ah_inen -> AH=00, z_f=1, s_f=0. Then ands with no ah_inen -> AH unchanged.
- Multiply: AH=00, AL=0D, breg=0B, muls for 8 cycles -> {AH,AL}=008F, md_done high only on edge 8. Repeat with FF x FF -> FE01, s_f=1.
- Divide: AL=C8, breg=07, divs for 8 cycles -> AL=1C, AH=04. Divide by zero: AL=35, breg=00 -> AL=FF, AH=35.
- Abort/reset mid-op: drop muls after 3 steps -> counter 0, no md_done, next full 8-step run gives correct product. Separately, clr=0 at step 5 -> all state 0, md_done never pulses.
- Bus/shift: ls=11, bus_in=81, then ls=10 -> AL=02; acc_oen=1 -> acc_out=02; acc_oen=0 -> acc_out=00.

Source files
------------

// File: rtl/accumulator_unit.sv
// Double-length accumulator (AH:AL) for the 8-bit CPU datapath: single-cycle ALU ops,
// shift/load modes and iterative one-bit-per-clock unsigned multiply/divide.
module accumulator_unit #(
   parameter int WIDTH = 8,
   parameter int STEPS = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] bus_in,
   input  logic [WIDTH-1:0] breg_in,
   input  logic             ah_inen,
   input  logic             ah_reset,
   input  logic             adds,
   input  logic             subs,
   input  logic             ands,
   input  logic             muls,
   input  logic             divs,
   input  logic [1:0]       hs,
   input  logic [1:0]       ls,
   input  logic             acc_oen,
   output logic [WIDTH-1:0] acc_out,
   output logic [WIDTH-1:0] ah_out,
   output logic             z_f,
   output logic             s_f,
   output logic             md_done
);

   logic [WIDTH-1:0] r_ah, r_al;
   logic [3:0]       r_cnt;
   logic             r_div_mode;
   logic             r_zf, r_sf, r_md_done;

   logic [WIDTH-1:0] w_ah_nxt, w_al_nxt, w_step_ah, w_step_al, w_alu_res;
   logic [3:0]       w_cnt_nxt, w_cnt_base;
   logic             w_div_mode_nxt, w_zf_nxt, w_sf_nxt, w_md_done_nxt;
   logic             w_md_step, w_do_div, w_last, w_alu_op;
   logic [WIDTH:0]   w_sum, w_t, w_d;

   function automatic logic [WIDTH-1:0] f_mode(input logic [1:0] mode,
                                                input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] load);
      case (mode)
         2'b00:   f_mode = cur;
         2'b01:   f_mode = {1'b0, cur[WIDTH-1:1]};
         2'b10:   f_mode = {cur[WIDTH-2:0], 1'b0};
         2'b11:   f_mode = load;
         default: f_mode = cur;
      endcase
   endfunction

   assign w_md_step = muls | divs;
   assign w_do_div  = divs & ~muls;
   assign w_alu_op  = adds | subs | ands;

   // One mul/div iteration; a change of operation mid-run restarts the count.
   always_comb begin
      w_cnt_base = r_cnt;
      w_sum      = {1'b0, r_ah};
      w_t        = {r_ah, r_al[WIDTH-1]};
      w_d        = w_t - {1'b0, breg_in};
      if ((r_cnt != 4'd0) && (w_do_div != r_div_mode)) begin
         w_cnt_base = 4'd0;
      end else begin
         w_cnt_base = r_cnt;
      end
      if (r_al[0]) begin
         w_sum = {1'b0, r_ah} + {1'b0, breg_in};
      end else begin
         w_sum = {1'b0, r_ah};
      end
      if (w_do_div) begin
         if (w_t >= {1'b0, breg_in}) begin
            w_step_ah = w_d[WIDTH-1:0];
            w_step_al = {r_al[WIDTH-2:0], 1'b1};
         end else begin
            w_step_ah = w_t[WIDTH-1:0];
            w_step_al = {r_al[WIDTH-2:0], 1'b0};
         end
      end else begin
         w_step_ah = w_sum[WIDTH:1];
         w_step_al = {w_sum[0], r_al[WIDTH-1:1]};
      end
      w_last = (w_cnt_base == 4'(STEPS - 1));
   end

   // ALU result: subs > adds > ands.
   always_comb begin
      if (subs) begin
         w_alu_res = r_ah - breg_in;
      end else if (adds) begin
         w_alu_res = r_ah + breg_in;
      end else if (ands) begin
         w_alu_res = r_ah & breg_in;
      end else begin
         w_alu_res = bus_in;
      end
   end

   // Next-state selection for AH, AL, step counter and flags.
   always_comb begin
      w_ah_nxt       = r_ah;
      w_al_nxt       = r_al;
      w_cnt_nxt      = 4'd0;
      w_div_mode_nxt = r_div_mode;
      w_zf_nxt       = r_zf;
      w_sf_nxt       = r_sf;
      w_md_done_nxt  = 1'b0;
      if (w_md_step) begin
         w_ah_nxt       = w_step_ah;
         w_al_nxt       = w_step_al;
         w_div_mode_nxt = w_do_div;
         if (w_last) begin
            w_cnt_nxt     = 4'd0;
            w_md_done_nxt = 1'b1;
            w_zf_nxt      = ({w_step_ah, w_step_al} == {(2*WIDTH){1'b0}});
            w_sf_nxt      = w_step_ah[WIDTH-1];
         end else begin
            w_cnt_nxt = w_cnt_base + 4'd1;
         end
      end else begin
         w_al_nxt = f_mode(ls, r_al, bus_in);
         if (ah_inen) begin
            w_ah_nxt = w_alu_res;
            if (w_alu_op && !ah_reset) begin
               w_zf_nxt = (w_alu_res == {WIDTH{1'b0}});
               w_sf_nxt = w_alu_res[WIDTH-1];
            end else begin
               w_zf_nxt = r_zf;
            end
         end else begin
            w_ah_nxt = f_mode(hs, r_ah, bus_in);
         end
      end
      if (ah_reset) begin
         w_ah_nxt = {WIDTH{1'b0}};
      end else begin
         w_ah_nxt = w_ah_nxt;
      end
   end

   // State register with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!clr) begin
         r_ah       <= {WIDTH{1'b0}};
         r_al       <= {WIDTH{1'b0}};
         r_cnt      <= 4'd0;
         r_div_mode <= 1'b0;
         r_zf       <= 1'b0;
         r_sf       <= 1'b0;
         r_md_done  <= 1'b0;
      end else begin
         r_ah       <= w_ah_nxt;
         r_al       <= w_al_nxt;
         r_cnt      <= w_cnt_nxt;
         r_div_mode <= w_div_mode_nxt;
         r_zf       <= w_zf_nxt;
         r_sf       <= w_sf_nxt;
         r_md_done  <= w_md_done_nxt;
      end
   end

   assign acc_out = acc_oen ? r_al : {WIDTH{1'b0}};
   assign ah_out  = r_ah;
   assign z_f     = r_zf;
   assign s_f     = r_sf;
   assign md_done = r_md_done;

endmodule

// File: tb/tb_accumulator_unit.sv
// Self-checking bench for accumulator_unit: directed scenarios plus randomized
// ALU/mul/div traffic compared against a plain-arithmetic reference model.
module tb_accumulator_unit;

   logic       clk = 1'b0;
   logic       clr;
   logic [7:0] bus_in, breg_in;
   logic       ah_inen, ah_reset, adds, subs, ands, muls, divs, acc_oen;
   logic [1:0] hs, ls;
   logic [7:0] acc_out, ah_out;
   logic       z_f, s_f, md_done;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] m_ah, m_al;
   logic       m_zf, m_sf;

   accumulator_unit #(.WIDTH(8), .STEPS(8)) dut (
      .clk(clk), .clr(clr), .bus_in(bus_in), .breg_in(breg_in),
      .ah_inen(ah_inen), .ah_reset(ah_reset), .adds(adds), .subs(subs),
      .ands(ands), .muls(muls), .divs(divs), .hs(hs), .ls(ls),
      .acc_oen(acc_oen), .acc_out(acc_out), .ah_out(ah_out),
      .z_f(z_f), .s_f(s_f), .md_done(md_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ah_inen = 1'b0; ah_reset = 1'b0; adds = 1'b0; subs = 1'b0; ands = 1'b0;
      muls = 1'b0; divs = 1'b0; hs = 2'b00; ls = 2'b00;
   endtask

   task automatic set_regs(input logic [7:0] a, input logic [7:0] l);
      idle();
      hs = 2'b11; bus_in = a; tick();
      hs = 2'b00; ls = 2'b11; bus_in = l; tick();
      ls = 2'b00;
      m_ah = a; m_al = l;
   endtask

   task automatic test_reset();
      idle(); acc_oen = 1'b1; bus_in = 8'h00; breg_in = 8'h00;
      clr = 1'b0; tick(); clr = 1'b1;
      set_regs(8'h5A, 8'hC3);
      n_vec++;
      if (ah_out !== 8'h5A || acc_out !== 8'hC3) begin
         n_err++; $display("FAIL reset_preload ah=%h al=%h want 5a c3", ah_out, acc_out);
      end
      clr = 1'b0; tick(); clr = 1'b1;
      n_vec++;
      if ({ah_out, acc_out, z_f, s_f, md_done} !== 19'h0) begin
         n_err++;
         $display("FAIL reset ah=%h acc=%h z=%b s=%b md=%b want all 0", ah_out, acc_out, z_f, s_f, md_done);
      end
      m_ah = 8'h00; m_al = 8'h00; m_zf = 1'b0; m_sf = 1'b0;
   endtask

   task automatic test_alu();
      idle(); hs = 2'b11; bus_in = 8'h7F; tick(); hs = 2'b00;
      breg_in = 8'h01; adds = 1'b1; ah_inen = 1'b1; tick();
      n_vec++;
      if (ah_out !== 8'h80 || s_f !== 1'b1 || z_f !== 1'b0) begin
         n_err++; $display("FAIL alu_add ah=%h z=%b s=%b want 80 0 1", ah_out, z_f, s_f);
      end
      adds = 1'b0; subs = 1'b1; breg_in = 8'h80; tick();
      n_vec++;
      if (ah_out !== 8'h00 || z_f !== 1'b1 || s_f !== 1'b0) begin
         n_err++; $display("FAIL alu_sub ah=%h z=%b s=%b want 00 1 0", ah_out, z_f, s_f);
      end
      idle(); hs = 2'b11; bus_in = 8'h3C; tick(); hs = 2'b00;
      ands = 1'b1; breg_in = 8'h0F; tick();
      n_vec++;
      if (ah_out !== 8'h3C || z_f !== 1'b1 || s_f !== 1'b0) begin
         n_err++; $display("FAIL alu_and_noinen ah=%h z=%b s=%b want 3c 1 0", ah_out, z_f, s_f);
      end
      idle();
      m_ah = 8'h3C; m_zf = 1'b1; m_sf = 1'b0;
   endtask

   task automatic test_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'(a) * 16'(b);
      set_regs(8'h00, a);
      breg_in = b; muls = 1'b1; acc_oen = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_vec++;
         if (md_done !== (i == 7)) begin
            n_err++; $display("FAIL mul_done step=%0d got=%b want=%b", i, md_done, (i == 7));
         end
      end
      muls = 1'b0;
      m_ah = p[15:8]; m_al = p[7:0]; m_zf = (p == 16'h0); m_sf = p[15];
      n_vec++;
      if ({ah_out, acc_out} !== p || z_f !== m_zf || s_f !== m_sf) begin
         n_err++;
         $display("FAIL mul %h*%h got=%h z=%b s=%b want=%h z=%b s=%b", a, b, {ah_out, acc_out}, z_f, s_f, p, m_zf, m_sf);
      end
      tick();
      n_vec++;
      if (md_done !== 1'b0) begin
         n_err++; $display("FAIL mul_done_pulse got=%b want=0", md_done);
      end
   endtask

   task automatic test_div(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] q, r;
      q = (b == 8'h00) ? 8'hFF : a / b;
      r = (b == 8'h00) ? a : a % b;
      set_regs(8'h00, a);
      breg_in = b; divs = 1'b1; acc_oen = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_vec++;
         if (md_done !== (i == 7)) begin
            n_err++; $display("FAIL div_done step=%0d got=%b want=%b", i, md_done, (i == 7));
         end
      end
      divs = 1'b0;
      m_ah = r; m_al = q; m_zf = ({r, q} == 16'h0); m_sf = r[7];
      n_vec++;
      if (acc_out !== q || ah_out !== r || z_f !== m_zf || s_f !== m_sf) begin
         n_err++;
         $display("FAIL div %h/%h got q=%h r=%h z=%b s=%b want q=%h r=%h z=%b s=%b", a, b, acc_out, ah_out, z_f, s_f, q, r, m_zf, m_sf);
      end
      tick();
   endtask

   task automatic test_abort();
      logic sv_z, sv_s;
      sv_z = z_f; sv_s = s_f;
      set_regs(8'h00, 8'h0D);
      breg_in = 8'h0B; muls = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (md_done !== 1'b0) begin
            n_err++; $display("FAIL abort_done step=%0d got=%b want=0", i, md_done);
         end
      end
      muls = 1'b0; tick();
      n_vec++;
      if (md_done !== 1'b0 || z_f !== sv_z || s_f !== sv_s) begin
         n_err++; $display("FAIL abort_flags md=%b z=%b s=%b want 0 %b %b", md_done, z_f, s_f, sv_z, sv_s);
      end
      test_mul(8'h0D, 8'h0B);
   endtask

   task automatic test_reset_midop();
      set_regs(8'h00, 8'hFF);
      breg_in = 8'hFF; muls = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      clr = 1'b0; tick(); clr = 1'b1;
      n_vec++;
      if ({ah_out, acc_out, z_f, s_f, md_done} !== 19'h0) begin
         n_err++;
         $display("FAIL reset_midop ah=%h acc=%h z=%b s=%b md=%b want all 0", ah_out, acc_out, z_f, s_f, md_done);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (md_done !== 1'b0) begin
            n_err++; $display("FAIL reset_midop_done step=%0d got=%b want=0", i, md_done);
         end
      end
      idle(); tick();
      m_zf = 1'b0; m_sf = 1'b0;
      set_regs(8'h00, 8'h00);
   endtask

   task automatic test_bus_shift();
      idle(); ls = 2'b11; bus_in = 8'h81; tick();
      ls = 2'b10; tick(); ls = 2'b00;
      acc_oen = 1'b1; #1;
      n_vec++;
      if (acc_out !== 8'h02) begin
         n_err++; $display("FAIL shift_left acc=%h want 02", acc_out);
      end
      acc_oen = 1'b0; #1;
      n_vec++;
      if (acc_out !== 8'h00) begin
         n_err++; $display("FAIL acc_oen_off acc=%h want 00", acc_out);
      end
      acc_oen = 1'b1;
      m_al = 8'h02;
   endtask

   task automatic test_back_to_back();
      int op;
      logic [7:0] b;
      for (int k = 0; k < 40; k++) begin
         idle();
         op = int'($urandom_range(0, 2));
         b  = 8'($urandom);
         breg_in = b; ah_inen = 1'b1;
         case (op)
            0: begin adds = 1'b1; m_ah = m_ah + b; end
            1: begin subs = 1'b1; m_ah = m_ah - b; end
            default: begin ands = 1'b1; m_ah = m_ah & b; end
         endcase
         m_zf = (m_ah == 8'h00); m_sf = m_ah[7];
         acc_oen = 1'($urandom);
         tick();
         n_vec++;
         if (ah_out !== m_ah || z_f !== m_zf || s_f !== m_sf || md_done !== 1'b0 ||
             acc_out !== (acc_oen ? m_al : 8'h00)) begin
            n_err++;
            $display("FAIL b2b_alu op=%0d ah=%h z=%b s=%b acc=%h want ah=%h z=%b s=%b al=%h", op, ah_out, z_f, s_f, acc_out, m_ah, m_zf, m_sf, m_al);
         end
      end
      idle();
   endtask

   task automatic test_random_md();
      for (int k = 0; k < 12; k++) begin
         if ($urandom_range(0, 1) == 0) test_mul(8'($urandom), 8'($urandom));
         else test_div(8'($urandom), 8'($urandom_range(0, 255)));
      end
   endtask

   initial begin
      clr = 1'b1; acc_oen = 1'b1; bus_in = 8'h00; breg_in = 8'h00;
      idle();
      test_reset();
      test_alu();
      test_mul(8'h0D, 8'h0B);
      test_mul(8'hFF, 8'hFF);
      test_div(8'hC8, 8'h07);
      test_div(8'h35, 8'h00);
      test_abort();
      test_reset_midop();
      test_bus_shift();
      test_back_to_back();
      test_random_md();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
